// File: rtl/dmem_arbiter.sv
// Core/debug arbiter for a single-port data memory with 1-cycle read latency.
// Define DMEM_ARB_RR_EN for round-robin contention; otherwise core has priority.
module dmem_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                core_req,
  input  logic                core_we,
  input  logic [ADDR_W-1:0]   core_addr,
  input  logic [DATA_W-1:0]   core_wdata,
  input  logic [DATA_W/8-1:0] core_wstrb,
  output logic                core_gnt,
  output logic                core_rvalid,
  output logic [DATA_W-1:0]   core_rdata,

  input  logic                dbg_req,
  input  logic                dbg_we,
  input  logic [ADDR_W-1:0]   dbg_addr,
  input  logic [DATA_W-1:0]   dbg_wdata,
  input  logic [DATA_W/8-1:0] dbg_wstrb,
  output logic                dbg_gnt,
  output logic                dbg_rvalid,
  output logic [DATA_W-1:0]   dbg_rdata,
  input  logic                dbg_lock,

  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CORE,
    OWN_DBG
  } owner_t;

  owner_t     owner;
  logic [3:0] starve;
  logic       rd_core;
  logic       rd_dbg;

  logic locked;
  logic core_ok;
  logic dbg_first;
  logic rr_dbg;
  logic pick_core;
  logic pick_dbg;

  // Debug wins when starved or holding the lock; otherwise core unless
  // round-robin says it is debug's turn.
  always_comb begin
    locked    = (owner == OWN_DBG) && dbg_lock;
    core_ok   = core_req && !locked;
    dbg_first = (starve == 4'hF) || locked;
`ifdef DMEM_ARB_RR_EN
    rr_dbg    = (owner == OWN_CORE);
`else
    rr_dbg    = 1'b0;
`endif
    pick_core = 1'b0;
    pick_dbg  = 1'b0;
    if (!rst) begin
      if (core_ok && !(dbg_req && (dbg_first || rr_dbg)))
        pick_core = 1'b1;
      else if (dbg_req)
        pick_dbg = 1'b1;
    end
  end

  always_comb begin
    core_gnt  = pick_core;
    dbg_gnt   = pick_dbg;
    mem_en    = pick_core || pick_dbg;
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (pick_core) begin
      mem_we    = core_we ? core_wstrb : '0;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
    end else if (pick_dbg) begin
      mem_we    = dbg_we ? dbg_wstrb : '0;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner   <= OWN_NONE;
      starve  <= '0;
      rd_core <= 1'b0;
      rd_dbg  <= 1'b0;
    end else begin
      rd_core <= pick_core && !core_we;
      rd_dbg  <= pick_dbg && !dbg_we;
      if (pick_core)
        owner <= OWN_CORE;
      else if (pick_dbg)
        owner <= OWN_DBG;
      // Counts only an unbroken run of denied debug requests.
      if (pick_dbg || !dbg_req)
        starve <= '0;
      else if (starve != 4'hF)
        starve <= starve + 4'd1;
    end
  end

  always_comb begin
    core_rvalid = rd_core;
    dbg_rvalid  = rd_dbg;
    core_rdata  = rd_core ? mem_rdata : '0;
    dbg_rdata   = rd_dbg ? mem_rdata : '0;
  end

endmodule
